// File: rtl/cp_gpp_endpoint_if.sv
// GPP communication-port and network-side signal bundle for cp_gpp_endpoint.
// The endpoint takes the slave modport; the GPP/network side takes the master modport.
interface cp_gpp_endpoint_if;
  logic        enable_rtr;
  logic        gpp_rtr_cp;
  logic        gpp_trf_dp;
  logic        gpp_rtr_dp;
  logic [15:0] gpp_tx_data;
  logic [15:0] RAM_rx_data_out;
  logic        data_rx_flag;
  logic        gpp_trf_cp;
  logic        tx_overflow;
  logic        net_rx_valid;
  logic [15:0] net_rx_data;
  logic        net_rx_ready;
  logic        net_tx_valid;
  logic [15:0] net_tx_data;
  logic        net_tx_last;
  logic        net_tx_ready;

  modport slave (
    input  enable_rtr, gpp_rtr_cp, gpp_trf_dp, gpp_rtr_dp, gpp_tx_data,
    input  net_rx_valid, net_rx_data, net_tx_ready,
    output RAM_rx_data_out, data_rx_flag, gpp_trf_cp, tx_overflow,
    output net_rx_ready, net_tx_valid, net_tx_data, net_tx_last
  );

  modport master (
    output enable_rtr, gpp_rtr_cp, gpp_trf_dp, gpp_rtr_dp, gpp_tx_data,
    output net_rx_valid, net_rx_data, net_tx_ready,
    input  RAM_rx_data_out, data_rx_flag, gpp_trf_cp, tx_overflow,
    input  net_rx_ready, net_tx_valid, net_tx_data, net_tx_last
  );
endinterface

// File: rtl/cp_gpp_endpoint.sv
// Communications-processor endpoint: buffers network words for GPP reads and
// streams GPP-written words to the network as committed packets.
module cp_gpp_endpoint #(
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned TX_DEPTH = 16
) (
  input logic                clk,
  input logic                rst,
  cp_gpp_endpoint_if.slave   bus
);
  localparam int unsigned RxAw = $clog2(RX_DEPTH);
  localparam int unsigned RxCw = RxAw + 1;
  localparam int unsigned TxAw = $clog2(TX_DEPTH);
  localparam int unsigned TxCw = TxAw + 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  logic [15:0]     rx_mem [RX_DEPTH];
  logic [RxAw-1:0] rx_wr_q, rx_rd_q;
  logic [RxCw-1:0] rx_cnt_q, rx_cnt_d;
  logic            rx_push, rx_pop;
  logic [15:0]     rx_data_q;
  logic            rx_flag_q, rx_ack_q, rx_ready_q;

  logic [15:0]     tx_mem [TX_DEPTH];
  logic [TxAw-1:0] tx_wr_q, tx_rd_q;
  logic [TxCw-1:0] tx_cnt_q, tx_cnt_d, tx_avail, rem_q;
  logic            tx_full, tx_push, tx_pop, commit, ovf_q;
  state_e          state_q;

  // RX side: network pushes gated by the registered ready, GPP pops when non-empty.
  assign rx_push = bus.net_rx_valid & rx_ready_q;
  assign rx_pop  = bus.enable_rtr & bus.gpp_rtr_cp & (rx_cnt_q != '0);

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + RxCw'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - RxCw'(1);
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= bus.net_rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      rx_data_q  <= '0;
      rx_flag_q  <= 1'b0;
      rx_ack_q   <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      rx_flag_q  <= (rx_cnt_d != '0);
      rx_ready_q <= (rx_cnt_d != RxCw'(RX_DEPTH));
      rx_ack_q   <= rx_pop;
      if (rx_push) rx_wr_q <= rx_wr_q + RxAw'(1);
      if (rx_pop) begin
        rx_rd_q   <= rx_rd_q + RxAw'(1);
        rx_data_q <= rx_mem[rx_rd_q];
      end
    end
  end

  assign bus.RAM_rx_data_out = rx_data_q;
  assign bus.data_rx_flag    = rx_flag_q;
  assign bus.gpp_trf_cp      = rx_ack_q;
  assign bus.net_rx_ready    = rx_ready_q;

  // TX side: a same-cycle push counts toward the length latched by a commit.
  assign tx_full  = (tx_cnt_q == TxCw'(TX_DEPTH));
  assign tx_push  = bus.enable_rtr & bus.gpp_trf_dp & ~tx_full;
  assign tx_pop   = (state_q == StSend) & bus.net_tx_ready;
  assign tx_avail = tx_cnt_q + TxCw'(tx_push);
  assign commit   = (state_q == StIdle) & bus.enable_rtr & bus.gpp_rtr_dp & (tx_avail != '0);

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + TxCw'(1);
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - TxCw'(1);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= bus.gpp_tx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
      state_q  <= StIdle;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      if (tx_push) tx_wr_q <= tx_wr_q + TxAw'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + TxAw'(1);
      if (bus.enable_rtr && bus.gpp_trf_dp && tx_full) ovf_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (commit) begin
            rem_q   <= tx_avail;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (bus.net_tx_ready) begin
            rem_q <= rem_q - TxCw'(1);
            if (rem_q == TxCw'(1)) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Data is gated so the output reads zero whenever no packet is in flight.
  assign bus.net_tx_valid = (state_q == StSend);
  assign bus.net_tx_data  = (state_q == StSend) ? tx_mem[tx_rd_q] : 16'h0000;
  assign bus.net_tx_last  = (state_q == StSend) && (rem_q == TxCw'(1));
  assign bus.tx_overflow  = ovf_q;
endmodule

// File: tb/tb_cp_gpp_endpoint.sv
// Directed bench for cp_gpp_endpoint: a queue-based model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_cp_gpp_endpoint;
  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  cp_gpp_endpoint_if bus ();

  cp_gpp_endpoint #(.RX_DEPTH(Depth), .TX_DEPTH(Depth)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: plain queues plus the number of words left in the packet.
  logic [15:0] rxq[$];
  logic [15:0] txq[$];
  int          left = 0;
  bit          started = 1'b0;
  logic [15:0] m_data = '0;
  bit          m_ack = 0, m_ovf = 0, m_rready = 0;

  always @(posedge clk) begin
    started = 1'b1;
    if (!rst) begin
      rxq.delete();
      txq.delete();
      left     = 0;
      m_data   = '0;
      m_ack    = 0;
      m_ovf    = 0;
      m_rready = 0;
    end else begin
      bit rpush, rpop, full, idle;
      rpush = bus.net_rx_valid && m_rready;
      rpop  = bus.enable_rtr && bus.gpp_rtr_cp && rxq.size() > 0;
      m_ack = rpop;
      if (rpop) m_data = rxq.pop_front();
      if (rpush) rxq.push_back(bus.net_rx_data);
      m_rready = rxq.size() < Depth;

      full = txq.size() == Depth;
      idle = left == 0;
      if (left > 0 && bus.net_tx_ready) begin
        void'(txq.pop_front());
        left--;
      end
      if (bus.enable_rtr && bus.gpp_trf_dp) begin
        if (full) m_ovf = 1;
        else txq.push_back(bus.gpp_tx_data);
      end
      if (idle && bus.enable_rtr && bus.gpp_rtr_dp && txq.size() > 0) left = txq.size();
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("RAM_rx_data_out", bus.RAM_rx_data_out, m_data);
      chk("data_rx_flag", {15'b0, bus.data_rx_flag}, {15'b0, rxq.size() > 0});
      chk("gpp_trf_cp", {15'b0, bus.gpp_trf_cp}, {15'b0, m_ack});
      chk("tx_overflow", {15'b0, bus.tx_overflow}, {15'b0, m_ovf});
      chk("net_rx_ready", {15'b0, bus.net_rx_ready}, {15'b0, m_rready});
      chk("net_tx_valid", {15'b0, bus.net_tx_valid}, {15'b0, left > 0});
      chk("net_tx_data", bus.net_tx_data, (left > 0) ? txq[0] : 16'h0000);
      chk("net_tx_last", {15'b0, bus.net_tx_last}, {15'b0, left == 1});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.enable_rtr   = 0;
    bus.gpp_rtr_cp   = 0;
    bus.gpp_trf_dp   = 0;
    bus.gpp_rtr_dp   = 0;
    bus.gpp_tx_data  = '0;
    bus.net_rx_valid = 0;
    bus.net_rx_data  = '0;
    bus.net_tx_ready = 0;
    step();
    step();
    chk("rst data", bus.RAM_rx_data_out, 16'h0000);
    chk("rst flag", {15'b0, bus.data_rx_flag}, 16'h0);
    chk("rst ack", {15'b0, bus.gpp_trf_cp}, 16'h0);
    chk("rst ovf", {15'b0, bus.tx_overflow}, 16'h0);
    chk("rst rready", {15'b0, bus.net_rx_ready}, 16'h0);
    chk("rst tvalid", {15'b0, bus.net_tx_valid}, 16'h0);
    rst = 1;
    step();
    chk("rready after rst", {15'b0, bus.net_rx_ready}, 16'h1);

    // Reset then RX
    bus.net_rx_valid = 1; bus.net_rx_data = 16'h1111; step();
    bus.net_rx_data = 16'h2222; step();
    bus.net_rx_valid = 0;
    chk("rx flag", {15'b0, bus.data_rx_flag}, 16'h1);
    bus.enable_rtr = 1; bus.gpp_rtr_cp = 1; step();
    chk("rd1 data", bus.RAM_rx_data_out, 16'h1111);
    chk("rd1 ack", {15'b0, bus.gpp_trf_cp}, 16'h1);
    step();
    chk("rd2 data", bus.RAM_rx_data_out, 16'h2222);
    chk("rd2 ack", {15'b0, bus.gpp_trf_cp}, 16'h1);
    bus.gpp_rtr_cp = 0; step();
    chk("rx flag empty", {15'b0, bus.data_rx_flag}, 16'h0);

    // RX full / empty
    bus.net_rx_valid = 1;
    for (int i = 0; i < 17; i++) begin
      bus.net_rx_data = 16'h3000 + 16'(i);
      step();
      if (i == 15) chk("rready full", {15'b0, bus.net_rx_ready}, 16'h0);
    end
    bus.net_rx_valid = 0;
    bus.gpp_rtr_cp = 1;
    for (int i = 0; i < 16; i++) step();
    chk("rx last word", bus.RAM_rx_data_out, 16'h300F);
    step();
    chk("rd empty ack", {15'b0, bus.gpp_trf_cp}, 16'h0);
    chk("rd empty data", bus.RAM_rx_data_out, 16'h300F);
    bus.gpp_rtr_cp = 0; bus.net_rx_valid = 1; bus.net_rx_data = 16'h4444; step();
    bus.net_rx_valid = 0; bus.enable_rtr = 0; bus.gpp_rtr_cp = 1; step();
    chk("rd disabled ack", {15'b0, bus.gpp_trf_cp}, 16'h0);
    chk("rd disabled data", bus.RAM_rx_data_out, 16'h300F);
    bus.enable_rtr = 1; step();
    chk("rd 4444", bus.RAM_rx_data_out, 16'h4444);
    bus.gpp_rtr_cp = 0;

    // TX packet
    bus.gpp_trf_dp = 1;
    for (int i = 1; i <= 3; i++) begin
      bus.gpp_tx_data = 16'hA000 + 16'(i);
      step();
    end
    bus.gpp_trf_dp = 0; bus.gpp_rtr_dp = 1; bus.net_tx_ready = 1; step();
    bus.gpp_rtr_dp = 0;
    for (int i = 1; i <= 3; i++) begin
      chk("pkt data", bus.net_tx_data, 16'hA000 + 16'(i));
      chk("pkt last", {15'b0, bus.net_tx_last}, (i == 3) ? 16'h1 : 16'h0);
      step();
    end
    chk("pkt done", {15'b0, bus.net_tx_valid}, 16'h0);

    // Backpressure and overlap
    bus.net_tx_ready = 0; bus.gpp_trf_dp = 1;
    bus.gpp_tx_data = 16'hC001; step();
    bus.gpp_tx_data = 16'hC002; step();
    bus.gpp_trf_dp = 0; bus.gpp_rtr_dp = 1; step();
    bus.gpp_rtr_dp = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp data", bus.net_tx_data, 16'hC001);
      chk("bp last", {15'b0, bus.net_tx_last}, 16'h0);
      bus.gpp_trf_dp = (i == 1); bus.gpp_tx_data = 16'hB000;
      bus.gpp_rtr_dp = (i == 3);
      step();
    end
    bus.gpp_trf_dp = 0; bus.gpp_rtr_dp = 0; bus.net_tx_ready = 1;
    chk("bp data held", bus.net_tx_data, 16'hC001);
    step();
    chk("bp data 2", bus.net_tx_data, 16'hC002);
    chk("bp last 2", {15'b0, bus.net_tx_last}, 16'h1);
    step();
    chk("mid-send commit ignored", {15'b0, bus.net_tx_valid}, 16'h0);
    bus.gpp_rtr_dp = 1; step();
    bus.gpp_rtr_dp = 0;
    chk("single word", bus.net_tx_data, 16'hB000);
    chk("single last", {15'b0, bus.net_tx_last}, 16'h1);
    step();

    // TX overflow and empty commit
    bus.gpp_rtr_dp = 1; step();
    bus.gpp_rtr_dp = 0;
    chk("empty commit", {15'b0, bus.net_tx_valid}, 16'h0);
    bus.gpp_trf_dp = 1;
    for (int i = 0; i < 17; i++) begin
      bus.gpp_tx_data = 16'hD000 + 16'(i);
      step();
    end
    bus.gpp_trf_dp = 0;
    chk("overflow set", {15'b0, bus.tx_overflow}, 16'h1);
    bus.gpp_rtr_dp = 1; step();
    bus.gpp_rtr_dp = 0;
    for (int i = 0; i < 16; i++) begin
      chk("ovf pkt data", bus.net_tx_data, 16'hD000 + 16'(i));
      step();
    end
    chk("ovf pkt done", {15'b0, bus.net_tx_valid}, 16'h0);
    chk("overflow sticky", {15'b0, bus.tx_overflow}, 16'h1);

    // Reset mid-packet
    bus.gpp_trf_dp = 1;
    for (int i = 0; i < 8; i++) begin
      bus.gpp_tx_data = 16'hE000 + 16'(i);
      step();
    end
    bus.gpp_trf_dp = 0; bus.gpp_rtr_dp = 1; step();
    bus.gpp_rtr_dp = 0;
    step(); step(); step();
    chk("mid data", bus.net_tx_data, 16'hE003);
    rst = 0; step();
    chk("rst mid valid", {15'b0, bus.net_tx_valid}, 16'h0);
    chk("rst mid ovf", {15'b0, bus.tx_overflow}, 16'h0);
    rst = 1; step();
    bus.gpp_rtr_dp = 1; step();
    bus.gpp_rtr_dp = 0;
    chk("commit after rst", {15'b0, bus.net_tx_valid}, 16'h0);
    step();
    chk("still idle", {15'b0, bus.net_tx_valid}, 16'h0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
